// File: rtl/vco_sweep_ctrl.sv
// Stepped-frequency sweep controller feeding the VCO increment word; parks on the peak-magnitude point.
// Latency: config and start take effect on the cycle after start; each point = dwell+1 settle cycles plus the measure wait.
// Backpressure: MEASURE waits indefinitely for mag_valid; start is ignored while busy; abort always wins.
//
// Ports:
//   clk50MHz, rst           - 50 MHz clock, synchronous active-high reset
//   start, abort            - single-cycle control pulses (abort has priority)
//   inc_start/stop/step     - sweep range (inclusive) and step, latched on an accepted start
//   dwell                   - settle cycles per point before sampling, latched on start
//   mag, mag_valid          - magnitude sample from the transducer-current path
//   increment               - increment word to the VCO (0 when idle)
//   busy, done, locked, err - status (done is a one-cycle pulse, err is sticky)
//   best_inc, best_mag      - point and value of the peak magnitude seen so far
//
// Optional build macro VCO_SWEEP_FINE_EN: after the coarse pass a fine pass
// around the coarse peak runs before locking.

module vco_sweep_ctrl #(
    parameter int INC_W   = 15,
    parameter int MAG_W   = 12,
    parameter int DWELL_W = 20
) (
    input  logic               clk50MHz,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [INC_W-1:0]   inc_start,
    input  logic [INC_W-1:0]   inc_stop,
    input  logic [INC_W-1:0]   inc_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [MAG_W-1:0]   mag,
    input  logic               mag_valid,
    output logic [INC_W-1:0]   increment,
    output logic               busy,
    output logic               done,
    output logic               locked,
    output logic               err,
    output logic [INC_W-1:0]   best_inc,
    output logic [MAG_W-1:0]   best_mag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        LOCK    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [INC_W-1:0]   inc_q, inc_d;
    logic [INC_W-1:0]   stop_q, stop_d;
    logic [INC_W-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [INC_W-1:0]   best_inc_q, best_inc_d;
    logic [MAG_W-1:0]   best_mag_q, best_mag_d;

    // Best point including the sample arriving this cycle, so a peak on the
    // final point is the one we park on.
    logic [INC_W-1:0]   cand_inc;
    logic [MAG_W-1:0]   cand_mag;
    // One extra bit so a step past the top of the range cannot wrap below stop.
    logic [INC_W:0]     next_inc;

`ifdef VCO_SWEEP_FINE_EN
    logic               fine_q, fine_d;
    logic [INC_W-1:0]   lo_q, lo_d;
    logic [INC_W-1:0]   fine_lo, fine_hi, fine_step;
    logic [INC_W:0]     fine_hi_sum;
`endif

    always_comb begin
        state_d    = state_q;
        inc_d      = inc_q;
        stop_d     = stop_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        locked_d   = locked_q;
        err_d      = err_q;
        best_inc_d = best_inc_q;
        best_mag_d = best_mag_q;

        // Strict compare: on a tie the earlier (lower) point is kept.
        if (mag > best_mag_q) begin
            cand_inc = inc_q;
            cand_mag = mag;
        end else begin
            cand_inc = best_inc_q;
            cand_mag = best_mag_q;
        end
        next_inc = {1'b0, inc_q} + {1'b0, step_q};

`ifdef VCO_SWEEP_FINE_EN
        fine_d = fine_q;
        lo_d   = lo_q;
        // Fine window is +/- one coarse step around the peak, clamped to the
        // original range; cand_inc >= lo_q always, so the subtraction is safe.
        if ({1'b0, cand_inc} >= ({1'b0, lo_q} + {1'b0, step_q})) begin
            fine_lo = cand_inc - step_q;
        end else begin
            fine_lo = lo_q;
        end
        fine_hi_sum = {1'b0, cand_inc} + {1'b0, step_q};
        if (fine_hi_sum > {1'b0, stop_q}) begin
            fine_hi = stop_q;
        end else begin
            fine_hi = fine_hi_sum[INC_W-1:0];
        end
        if ((step_q >> 3) == '0) begin
            fine_step = INC_W'(1);
        end else begin
            fine_step = step_q >> 3;
        end
`endif

        if (abort) begin
            state_d  = IDLE;
            inc_d    = '0;
            busy_d   = 1'b0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, LOCK: begin
                    if (start) begin
                        stop_d   = inc_stop;
                        step_d   = inc_step;
                        dwell_d  = dwell;
                        locked_d = 1'b0;
                        if ((inc_step == '0) || (inc_start > inc_stop)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            inc_d   = '0;
                            busy_d  = 1'b0;
                        end else begin
                            err_d      = 1'b0;
                            busy_d     = 1'b1;
                            inc_d      = inc_start;
                            best_inc_d = inc_start;
                            best_mag_d = '0;
                            cnt_d      = dwell;
                            state_d    = SETTLE;
`ifdef VCO_SWEEP_FINE_EN
                            fine_d     = 1'b0;
                            lo_d       = inc_start;
`endif
                        end
                    end
                end
                SETTLE: begin
                    // dwell=N gives N+1 settle cycles; dwell=0 is a single cycle.
                    if (cnt_q == '0) begin
                        state_d = MEASURE;
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                MEASURE: begin
                    if (mag_valid) begin
                        best_inc_d = cand_inc;
                        best_mag_d = cand_mag;
                        if (next_inc > {1'b0, stop_q}) begin
`ifdef VCO_SWEEP_FINE_EN
                            if (!fine_q) begin
                                fine_d  = 1'b1;
                                inc_d   = fine_lo;
                                stop_d  = fine_hi;
                                step_d  = fine_step;
                                cnt_d   = dwell_q;
                                state_d = SETTLE;
                            end else begin
                                state_d  = LOCK;
                                inc_d    = cand_inc;
                                locked_d = 1'b1;
                                busy_d   = 1'b0;
                                done_d   = 1'b1;
                            end
`else
                            state_d  = LOCK;
                            inc_d    = cand_inc;
                            locked_d = 1'b1;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
`endif
                        end else begin
                            inc_d   = next_inc[INC_W-1:0];
                            cnt_d   = dwell_q;
                            state_d = SETTLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            state_q    <= IDLE;
            inc_q      <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            best_inc_q <= '0;
            best_mag_q <= '0;
`ifdef VCO_SWEEP_FINE_EN
            fine_q     <= 1'b0;
            lo_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            inc_q      <= inc_d;
            stop_q     <= stop_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            best_inc_q <= best_inc_d;
            best_mag_q <= best_mag_d;
`ifdef VCO_SWEEP_FINE_EN
            fine_q     <= fine_d;
            lo_q       <= lo_d;
`endif
        end
    end

    assign increment = inc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign best_inc  = best_inc_q;
    assign best_mag  = best_mag_q;

endmodule

// File: tb/tb_vco_sweep_ctrl.sv
// Directed testbench for vco_sweep_ctrl: hand-computed sweep traces and status values.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// The measurement path replies a fixed number of cycles after each settle period.

module tb_vco_sweep_ctrl;

    localparam int INC_W   = 15;
    localparam int MAG_W   = 12;
    localparam int DWELL_W = 20;

    logic               clk50MHz = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [INC_W-1:0]   inc_start;
    logic [INC_W-1:0]   inc_stop;
    logic [INC_W-1:0]   inc_step;
    logic [DWELL_W-1:0] dwell;
    logic [MAG_W-1:0]   mag;
    logic               mag_valid;
    logic [INC_W-1:0]   increment;
    logic               busy;
    logic               done;
    logic               locked;
    logic               err;
    logic [INC_W-1:0]   best_inc;
    logic [MAG_W-1:0]   best_mag;

    int n_vec    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    int cur_dwell = 0;

    vco_sweep_ctrl #(
        .INC_W   (INC_W),
        .MAG_W   (MAG_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk50MHz  (clk50MHz),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .inc_start (inc_start),
        .inc_stop  (inc_stop),
        .inc_step  (inc_step),
        .dwell     (dwell),
        .mag       (mag),
        .mag_valid (mag_valid),
        .increment (increment),
        .busy      (busy),
        .done      (done),
        .locked    (locked),
        .err       (err),
        .best_inc  (best_inc),
        .best_mag  (best_mag)
    );

    always #10 clk50MHz = ~clk50MHz;

    // Reads the pre-edge value of done, so each high cycle counts once.
    always @(posedge clk50MHz) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic cyc();
        @(negedge clk50MHz);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start with a configuration; returns on the falling edge right
    // after the edge that sampled start.
    task automatic kick(input int s, input int e, input int st, input int d);
        inc_start = INC_W'(s);
        inc_stop  = INC_W'(e);
        inc_step  = INC_W'(st);
        dwell     = DWELL_W'(d);
        cur_dwell = d;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    // One sweep point, entered on the falling edge after the point began.
    // A decoy sample lands on the last settle edge and must be ignored; the
    // real sample arrives two cycles after settling ends. With poke set,
    // start is pulsed with junk config while busy and must be ignored too.
    task automatic measure(input logic [MAG_W-1:0] m, input int exp_inc, input bit poke);
        check_val("point_inc", 32'(increment), 32'(exp_inc));
        if (poke) begin
            inc_start = INC_W'(5);
            inc_stop  = INC_W'(6);
            inc_step  = INC_W'(1);
            dwell     = DWELL_W'(7);
        end
        repeat (cur_dwell) cyc();
        mag = MAG_W'(4095); mag_valid = 1'b1; start = poke;
        cyc();
        mag_valid = 1'b0; start = 1'b0;
        cyc();
        mag = m; mag_valid = 1'b1; start = poke;
        cyc();
        mag_valid = 1'b0; mag = '0; start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mag_valid = 1'b0; mag = '0;
        inc_start = '0; inc_stop = '0; inc_step = '0; dwell = '0;
        cyc();
        cyc();
        rst = 1'b0;
        check_val("rst_increment", 32'(increment), 0);
        check_val("rst_busy",      32'(busy),      0);
        check_val("rst_done",      32'(done),      0);
        check_val("rst_locked",    32'(locked),    0);
        check_val("rst_err",       32'(err),       0);
        check_val("rst_best_inc",  32'(best_inc),  0);
        check_val("rst_best_mag",  32'(best_mag),  0);
        cyc();

`ifndef VCO_SWEEP_FINE_EN
        // Basic sweep 26000..26040 step 10, peak 900 at 26020.
        kick(26000, 26040, 10, 3);
        check_val("t2_busy", 32'(busy), 1);
        check_val("t2_err",  32'(err),  0);
        measure(12'd100, 26000, 1'b0);
        measure(12'd400, 26010, 1'b0);
        measure(12'd900, 26020, 1'b0);
        measure(12'd300, 26030, 1'b0);
        measure(12'd50,  26040, 1'b0);
        check_val("t2_done",     32'(done),      1);
        check_val("t2_locked",   32'(locked),    1);
        check_val("t2_busy_end", 32'(busy),      0);
        check_val("t2_inc",      32'(increment), 26020);
        check_val("t2_best_mag", 32'(best_mag),  900);
        cyc();
        check_val("t2_done_low", 32'(done), 0);
        repeat (5) cyc();
        check_val("t2_lock_hold", 32'(increment), 26020);
        check_val("t2_done_cnt",  32'(done_cnt),  1);

        // Partial range: 130 exceeds 125, so only three points; tie keeps 100.
        kick(100, 125, 10, 2);
        check_val("t3_locked_clr", 32'(locked), 0);
        measure(12'd500, 100, 1'b0);
        measure(12'd500, 110, 1'b0);
        measure(12'd200, 120, 1'b0);
        check_val("t3_done",     32'(done),      1);
        check_val("t3_inc",      32'(increment), 100);
        check_val("t3_best_inc", 32'(best_inc),  100);
        check_val("t3_best_mag", 32'(best_mag),  500);
        cyc();

        // Single point range.
        kick(300, 300, 7, 0);
        measure(12'd7, 300, 1'b0);
        check_val("t3s_locked",   32'(locked),    1);
        check_val("t3s_inc",      32'(increment), 300);
        check_val("t3s_best_mag", 32'(best_mag),  7);
        cyc();

        // Abort while locked.
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_val("ablk_locked",   32'(locked),    0);
        check_val("ablk_inc",      32'(increment), 0);
        check_val("ablk_best_inc", 32'(best_inc),  300);

        // Top of range: 32765+5 must not wrap back under the stop value.
        kick(32760, 32767, 5, 0);
        measure(12'd10, 32760, 1'b0);
        measure(12'd20, 32765, 1'b0);
        check_val("wrap_locked", 32'(locked),    1);
        check_val("wrap_inc",    32'(increment), 32765);
        cyc();

        // Config errors from LOCK.
        kick(50, 60, 0, 1);
        check_val("cfg0_err",    32'(err),       1);
        check_val("cfg0_busy",   32'(busy),      0);
        check_val("cfg0_inc",    32'(increment), 0);
        check_val("cfg0_locked", 32'(locked),    0);
        cyc();
        kick(200, 100, 1, 1);
        check_val("cfg1_err",  32'(err),  1);
        check_val("cfg1_busy", 32'(busy), 0);
        cyc();

        // Valid start clears err; start while busy ignored; abort in MEASURE.
        kick(1000, 1050, 10, 2);
        check_val("t5_err",  32'(err),  0);
        check_val("t5_busy", 32'(busy), 1);
        measure(12'd30, 1000, 1'b0);
        measure(12'd80, 1010, 1'b1);
        check_val("t5_pt3_inc", 32'(increment), 1020);
        repeat (cur_dwell + 1) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_val("t5_ab_inc",      32'(increment), 0);
        check_val("t5_ab_busy",     32'(busy),      0);
        check_val("t5_ab_done",     32'(done),      0);
        check_val("t5_ab_locked",   32'(locked),    0);
        check_val("t5_ab_err",      32'(err),       0);
        check_val("t5_ab_best_mag", 32'(best_mag),  80);
        check_val("t5_ab_best_inc", 32'(best_inc),  1010);

        // start and abort together: abort wins.
        inc_start = INC_W'(400); inc_stop = INC_W'(500); inc_step = INC_W'(10); dwell = '0;
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        check_val("sa_busy", 32'(busy),      0);
        check_val("sa_inc",  32'(increment), 0);
        repeat (3) cyc();
        check_val("sa_busy_later", 32'(busy),     0);
        check_val("total_done",    32'(done_cnt), 4);
`else
        // Coarse pass peaks at 26020, fine pass 26010..26030 step 1 finds 26021.
        kick(26000, 26040, 10, 1);
        measure(12'd100, 26000, 1'b0);
        measure(12'd400, 26010, 1'b0);
        measure(12'd900, 26020, 1'b0);
        measure(12'd300, 26030, 1'b0);
        measure(12'd50,  26040, 1'b0);
        check_val("fine_busy",  32'(busy),      1);
        check_val("fine_done0", 32'(done),      0);
        check_val("fine_lock0", 32'(locked),    0);
        for (int k = 0; k <= 20; k++) begin
            measure((26010 + k == 26021) ? 12'd950 : 12'd100, 26010 + k, 1'b0);
        end
        check_val("fine_done",     32'(done),      1);
        check_val("fine_locked",   32'(locked),    1);
        check_val("fine_inc",      32'(increment), 26021);
        check_val("fine_best_mag", 32'(best_mag),  950);
        cyc();
        cyc();
        check_val("fine_done_cnt", 32'(done_cnt), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vco_sweep_ctrl.md
Name: vco_sweep_ctrl

Overview:
- Upstream stage of the VCO: generates the 15-bit frequency increment word that drives the VCO (f = increment*50e6/2^24 Hz).
- Runs a stepped frequency sweep. At each point it waits a settle dwell, then takes one magnitude sample from the transducer-current measurement path.
- Tracks the peak magnitude and, at sweep end, parks the increment on the resonance point (locked).

Parameters:
INC_W, 15, width of increment words (matches VCO increment input)
MAG_W, 12, width of magnitude sample
DWELL_W, 20, width of settle-dwell counter

Ports:
clk50MHz  input  1  system clock, 50 MHz
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a sweep when not busy
abort  input  1  single-cycle pulse; cancels sweep/lock
inc_start  input  INC_W  first sweep point
inc_stop  input  INC_W  last allowed sweep point (inclusive)
inc_step  input  INC_W  step between points, must be nonzero
dwell  input  DWELL_W  settle cycles per point before sampling
mag  input  MAG_W  magnitude sample
mag_valid  input  1  mag qualifier, one cycle per sample
increment  output  INC_W  to VCO increment input
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep completion
locked  output  1  increment parked on best point
err  output  1  sticky config error, cleared by next accepted start
best_inc  output  INC_W  increment of peak magnitude
best_mag  output  MAG_W  peak magnitude

Behaviour:
- Reset: all outputs 0, FSM=IDLE. increment=0, so the VCO is held still.
- FSM states: IDLE, SETTLE, MEASURE, LOCK. All outputs are registered.
- start in IDLE or LOCK:
  - Latch inc_start, inc_stop, inc_step and dwell.
  - If inc_step==0 or inc_start>inc_stop: err<=1, go to IDLE, increment<=0, locked<=0.
  - Otherwise: err<=0, locked<=0, busy<=1, increment<=inc_start, best_inc<=inc_start, best_mag<=0, dwell counter<=dwell, go to SETTLE.
  - The new values are visible on the cycle after start.
- start while busy (SETTLE/MEASURE): ignored.
- SETTLE: counter decrements once per cycle. When the counter reads 0, go to MEASURE; dwell=0 means a single SETTLE cycle. mag_valid is ignored in SETTLE.
- MEASURE: waits indefinitely for mag_valid. On the mag_valid cycle:
  - If mag > best_mag (strict): best_mag<=mag, best_inc<=increment. On a tie the earlier, lower point is kept.
  - Compute next = increment + step in INC_W+1 bits, so there is no wrap-around.
  - If next > inc_stop: go to LOCK with increment<=best_inc (including an update made on this same sample), locked<=1, busy<=0, done<=1 for exactly one cycle.
  - Otherwise: increment<=next[INC_W-1:0], reload the dwell counter, go to SETTLE.
- Sweep points are inc_start + k*inc_step <= inc_stop. When inc_start==inc_stop there is exactly one point.
- LOCK: increment holds best_inc until start or abort.
- abort (any state): next cycle increment<=0, busy<=0, locked<=0, FSM=IDLE, no done pulse. best_inc and best_mag are retained; err is unchanged.
- abort and start in the same cycle: abort wins and start is dropped.
- rst mid-sweep: immediate return to reset values on the next edge.

Optional Feature:
- Macro: VCO_SWEEP_FINE_EN.
- Defined: after the coarse pass completes, a fine pass runs with no LOCK in between.
  - Fine range: [best_inc - inc_step, best_inc + inc_step], clamped to [inc_start, inc_stop].
  - Fine step: max(inc_step>>3, 1).
  - best_inc and best_mag carry over with the same strict-greater rule.
  - busy stays 1 throughout; done/locked assert only after the fine pass.
- Undefined: single coarse pass only; no fine-pass logic is synthesized.

Test Plan:
1. Reset: assert rst 2 cycles -> increment=0, busy=0, done=0, locked=0, err=0, best_inc=0, best_mag=0.
2. Sweep: start=26000, stop=26040, step=10, dwell=3; mag=100,400,900,300,50 returned 2 cycles after SETTLE ends (fine off):
   - increment visits 26000..26040, with each point held for 4 settle cycles plus the measure wait.
   - Then locked=1, increment=26020, best_mag=900, exactly one done pulse.
3. Tie / partial range: start=100, stop=125, step=10; mag=500,500,200 -> only points 100, 110, 120 visited; best_inc=100 (tie keeps lower); start=stop=300 -> one point, locked at 300.
4. Config error: step=0 or start=200 > stop=100 -> err=1, busy=0, increment=0. A following valid start -> err=0 and the sweep runs.
5. Abort: abort during MEASURE of the 3rd point -> next cycle increment=0, busy=0, no done. start+abort in the same cycle -> stays IDLE. start pulsed while busy -> sweep unaffected.
6. VCO_SWEEP_FINE_EN: case 2 with a peak of mag 950 at 26021 -> fine pass covers 26010..26030 in step 1, final increment=26021, single done pulse after the fine pass.
